alu_control_seq: RTL and testbench
==================================

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 SHALL provide parameter ALUOP_W, default 4, width of ALUOp.
REQ-002 SHALL provide parameter MULT_CYCLES, default 4, latency (accept to out_valid) of MULT/MULTU; values below 2 are treated as 2.
REQ-003 SHALL provide parameter DIV_CYCLES, default 16, latency of DIV/DIVU; values below 2 are treated as 2.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  ALUOp/ALUFunction valid this cycle.
REQ-007 in_ready  output  1  block accepts a new op this cycle.
REQ-008 ALUOp  input  ALUOP_W  class code from main control unit.
REQ-009 ALUFunction  input  6  R-type funct field.
REQ-010 out_valid  output  1  decoded result valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 ALUOperation  output  4  registered ALU operation code.
REQ-013 Jr  output  1  registered jump-register flag.
REQ-014 Illegal  output  1  registered unsupported-op flag.
REQ-015 Busy  output  1  high while a multi-cycle op counts down.

Function
REQ-016 Decode, ALUOp=0111 by funct: 100000->0000, 100010->0001, 100101->0010, 100100->0011, 100111->0100, 000000->0110, 000010->0111, 101010->1100, 011000->1000, 011001->1001, 011010->1010, 011011->1011, 001000->0000 with Jr=1.
REQ-017 Decode, other ALUOp (funct ignored): 0000/0100/0101->0000, 0001->0010, 0010->0011, 0011->0101, 1000/1001->0001; upper ALUOp bits beyond bit 3 SHALL be zero for a match.
REQ-018 Any unmatched selector SHALL yield ALUOperation=1111, Illegal=1, Jr=0, single-cycle latency.
REQ-019 States: IDLE, HOLD, WAIT; transfer in on in_valid&in_ready, out on out_valid&out_ready.
REQ-020 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, 0 in WAIT.
REQ-021 Single-cycle op accepted: next state HOLD, out_valid=1 the following cycle (latency 1).
REQ-022 Multi-cycle op accepted: next state WAIT, counter loaded with N-2 (N = MULT_CYCLES or DIV_CYCLES), Busy=1; counter decrements each cycle; at 0 go HOLD, so out_valid rises exactly N cycles after acceptance.
REQ-023 HOLD with out_ready=0: all outputs held stable.
REQ-024 HOLD with out_ready=1 and new accept: replace outputs, stay HOLD (single) or go WAIT (multi); no bubble for back-to-back single-cycle ops.
REQ-025 HOLD with out_ready=1, no accept: go IDLE, out_valid=0.
REQ-026 ALUOp/ALUFunction SHALL be sampled only at accept; later input changes SHALL not affect outputs.
REQ-027 Counter width SHALL be $clog2(max(MULT_CYCLES,DIV_CYCLES)) minimum 1; no wrap below 0.

Reset
REQ-028 reset low SHALL immediately force IDLE, counter 0, out_valid=0, Busy=0, ALUOperation=0000, Jr=0, Illegal=0, in_ready=1 one cycle after deassert.
REQ-029 reset mid-WAIT or mid-HOLD SHALL discard the pending op; no out_valid after release.

Configuration
REQ-030 Macro ALU_CONTROL_DIV_EN defined: DIV/DIVU decode per REQ-016 with DIV_CYCLES latency.
REQ-031 Macro ALU_CONTROL_DIV_EN undefined: funct 011010/011011 SHALL decode as illegal per REQ-018, DIV_CYCLES unused.

Verification
REQ-032 reset low during WAIT of MULT -> outputs zero at once, out_valid stays 0 after release.
REQ-033 ADD, SUB, OR back-to-back with out_ready=1 -> out_valid 3 consecutive cycles, ALUOperation 0000,0001,0010, in_ready constant 1.
REQ-034 MULT accepted cycle 0, MULT_CYCLES=4, out_ready=1 -> Busy cycles 1-3, out_valid and ALUOperation=1000 at cycle 4, in_ready=0 cycles 1-3.
REQ-035 LUI accepted, out_ready=0 for 5 cycles, inputs toggled -> ALUOperation=0101 stable, in_ready=0, out_valid=1 throughout.
REQ-036 ALUOp=0111 funct=001000 -> Jr=1, Illegal=0; ALUOp=0111 funct=111111 -> 1111, Illegal=1.
REQ-037 DIV with and without ALU_CONTROL_DIV_EN, DIV_CYCLES=16 -> 1010 at cycle 16 vs 1111 Illegal=1 at cycle 1.

Source files
------------

// File: rtl/alu_control_seq_if.sv
// rtl/alu_control_seq_if.sv - handshake bundle between the control sequencer and its producer/consumer
interface alu_control_seq_if #(
  parameter int ALUOP_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] ALUOp;
  logic [5:0]         ALUFunction;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         ALUOperation;
  logic               Jr;
  logic               Illegal;
  logic               Busy;

  modport master (
    output in_valid, ALUOp, ALUFunction, out_ready,
    input  in_ready, out_valid, ALUOperation, Jr, Illegal, Busy
  );

  modport slave (
    input  in_valid, ALUOp, ALUFunction, out_ready,
    output in_ready, out_valid, ALUOperation, Jr, Illegal, Busy
  );
endinterface

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - ALU control decoder with valid/ready handshake and multi-cycle MULT/DIV sequencing (optional DIV via ALU_CONTROL_DIV_EN)
module alu_control_seq #(
  parameter int ALUOP_W     = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_control_seq_if.slave  bus
);
  // Latencies below 2 cannot be expressed by the WAIT countdown, so clamp them.
  localparam int MULT_N = (MULT_CYCLES < 2) ? 2 : MULT_CYCLES;
  localparam int DIV_N  = (DIV_CYCLES < 2) ? 2 : DIV_CYCLES;
  localparam int MAX_N  = (MULT_N > DIV_N) ? MULT_N : DIV_N;
  localparam int CNT_W  = ($clog2(MAX_N) < 1) ? 1 : $clog2(MAX_N);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WAIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic               r_jr;
  logic               r_ill;

  logic               w_upper_zero;
  logic [3:0]         w_sel;
  logic [3:0]         w_op;
  logic               w_jr;
  logic               w_ill;
  logic               w_mult;
  logic               w_div;
  logic               w_multi;
  logic               w_in_ready;
  logic               w_accept;
  logic [CNT_W-1:0]   w_cnt_load;

  // ALUOp wider than 4 bits only matches when the extra bits are zero.
  assign w_upper_zero = (bus.ALUOp & ~ALUOP_W'(4'hF)) == '0;
  assign w_sel        = bus.ALUOp[3:0];

  // Combinational decode of the presented selector; unmatched falls through as illegal.
  always_comb begin
    w_op   = 4'b1111;
    w_jr   = 1'b0;
    w_ill  = 1'b1;
    w_mult = 1'b0;
    w_div  = 1'b0;
    if (w_upper_zero) begin
      case (w_sel)
        4'b0111: begin
          case (bus.ALUFunction)
            6'b100000: begin w_op = 4'b0000; w_ill = 1'b0; end
            6'b100010: begin w_op = 4'b0001; w_ill = 1'b0; end
            6'b100101: begin w_op = 4'b0010; w_ill = 1'b0; end
            6'b100100: begin w_op = 4'b0011; w_ill = 1'b0; end
            6'b100111: begin w_op = 4'b0100; w_ill = 1'b0; end
            6'b000000: begin w_op = 4'b0110; w_ill = 1'b0; end
            6'b000010: begin w_op = 4'b0111; w_ill = 1'b0; end
            6'b101010: begin w_op = 4'b1100; w_ill = 1'b0; end
            6'b011000: begin w_op = 4'b1000; w_ill = 1'b0; w_mult = 1'b1; end
            6'b011001: begin w_op = 4'b1001; w_ill = 1'b0; w_mult = 1'b1; end
`ifdef ALU_CONTROL_DIV_EN
            6'b011010: begin w_op = 4'b1010; w_ill = 1'b0; w_div = 1'b1; end
            6'b011011: begin w_op = 4'b1011; w_ill = 1'b0; w_div = 1'b1; end
`endif
            6'b001000: begin w_op = 4'b0000; w_ill = 1'b0; w_jr = 1'b1; end
            default: ;
          endcase
        end
        4'b0000, 4'b0100, 4'b0101: begin w_op = 4'b0000; w_ill = 1'b0; end
        4'b0001:                   begin w_op = 4'b0010; w_ill = 1'b0; end
        4'b0010:                   begin w_op = 4'b0011; w_ill = 1'b0; end
        4'b0011:                   begin w_op = 4'b0101; w_ill = 1'b0; end
        4'b1000, 4'b1001:          begin w_op = 4'b0001; w_ill = 1'b0; end
        default: ;
      endcase
    end
  end

  assign w_multi = w_mult | w_div;

`ifdef ALU_CONTROL_DIV_EN
  assign w_cnt_load = w_div ? CNT_W'(DIV_N - 2) : CNT_W'(MULT_N - 2);
`else
  assign w_cnt_load = CNT_W'(MULT_N - 2);
`endif

  assign w_in_ready = (r_state == S_IDLE) ? 1'b1 :
                      (r_state == S_HOLD) ? bus.out_ready : 1'b0;
  assign w_accept   = bus.in_valid & w_in_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accepts route to HOLD or WAIT, drained results fall back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_multi ? S_WAIT : S_HOLD;
      S_HOLD: if (bus.out_ready) begin
        if (w_accept) w_state_nxt = w_multi ? S_WAIT : S_HOLD;
        else          w_state_nxt = S_IDLE;
      end
      S_WAIT: if (r_cnt == '0) w_state_nxt = S_HOLD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Countdown for multi-cycle ops; loaded with N-2 so out_valid lands N cycles after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 r_cnt <= '0;
    else if (w_accept && w_multi)               r_cnt <= w_cnt_load;
    else if (r_state == S_WAIT && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  // Decoded result captured only at accept so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op  <= 4'b0000;
      r_jr  <= 1'b0;
      r_ill <= 1'b0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_jr  <= w_jr;
      r_ill <= w_ill;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = (r_state == S_HOLD);
  assign bus.Busy         = (r_state == S_WAIT);
  assign bus.ALUOperation = r_op;
  assign bus.Jr           = r_jr;
  assign bus.Illegal      = r_ill;
endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq
module tb_alu_control_seq;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  alu_control_seq_if #(.ALUOP_W(4)) bus ();

  alu_control_seq #(
    .ALUOP_W    (4),
    .MULT_CYCLES(4),
    .DIV_CYCLES (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid    = 1'b0;
    bus.ALUOp       = 4'b0000;
    bus.ALUFunction = 6'b000000;
    bus.out_ready   = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    #1;
    n_total++;
    if ({bus.out_valid, bus.Busy, bus.ALUOperation, bus.Jr, bus.Illegal} !== 8'b0)
      $display("FAIL reset_outputs: got %b expected %b",
               {bus.out_valid, bus.Busy, bus.ALUOperation, bus.Jr, bus.Illegal}, 8'b0);
    else n_pass++;
    step();
    reset = 1'b1;
    step();
    n_total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [5:0] fn [3];
    logic [3:0] ex [3];
    fn[0] = 6'b100000; fn[1] = 6'b100010; fn[2] = 6'b100101;
    ex[0] = 4'b0000;   ex[1] = 4'b0001;   ex[2] = 4'b0010;
    bus.out_ready = 1'b1;
    bus.ALUOp     = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid    = 1'b1;
      bus.ALUFunction = fn[i];
      #1;
      n_total++;
      if (bus.in_ready !== 1'b1)
        $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
      else n_pass++;
      step();
      n_total++;
      if ({bus.out_valid, bus.ALUOperation} !== {1'b1, ex[i]})
        $display("FAIL b2b_result[%0d]: got %b expected %b", i,
                 {bus.out_valid, bus.ALUOperation}, {1'b1, ex[i]});
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    step();
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL b2b_drain: got out_valid %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_mult;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.ALUOp       = 4'b0111;
    bus.ALUFunction = 6'b011000;
    step();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_total++;
      if ({bus.Busy, bus.in_ready, bus.out_valid} !== 3'b100)
        $display("FAIL mult_wait[c%0d]: got busy/in_ready/out_valid %b expected 100", c,
                 {bus.Busy, bus.in_ready, bus.out_valid});
      else n_pass++;
      step();
    end
    n_total++;
    if ({bus.out_valid, bus.Busy, bus.ALUOperation} !== 6'b10_1000)
      $display("FAIL mult_done: got %b expected 101000",
               {bus.out_valid, bus.Busy, bus.ALUOperation});
    else n_pass++;
    step();
  endtask

  task automatic test_hold_stall;
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.ALUOp       = 4'b0011;
    bus.ALUFunction = 6'b000000;
    step();
    for (int c = 0; c < 5; c++) begin
      bus.ALUOp       = 4'(c * 3 + 1);
      bus.ALUFunction = 6'(c * 11 + 7);
      #1;
      n_total++;
      if ({bus.out_valid, bus.in_ready, bus.ALUOperation} !== 6'b10_0101)
        $display("FAIL hold_stall[%0d]: got %b expected 100101", c,
                 {bus.out_valid, bus.in_ready, bus.ALUOperation});
      else n_pass++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL hold_release: got out_valid %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_decode;
    logic [3:0] op [20];
    logic [5:0] fn [20];
    logic [5:0] ex [20];
    op[0]  = 4'b0111; fn[0]  = 6'b100000; ex[0]  = 6'b0000_00;
    op[1]  = 4'b0111; fn[1]  = 6'b100010; ex[1]  = 6'b0001_00;
    op[2]  = 4'b0111; fn[2]  = 6'b100101; ex[2]  = 6'b0010_00;
    op[3]  = 4'b0111; fn[3]  = 6'b100100; ex[3]  = 6'b0011_00;
    op[4]  = 4'b0111; fn[4]  = 6'b100111; ex[4]  = 6'b0100_00;
    op[5]  = 4'b0111; fn[5]  = 6'b000000; ex[5]  = 6'b0110_00;
    op[6]  = 4'b0111; fn[6]  = 6'b000010; ex[6]  = 6'b0111_00;
    op[7]  = 4'b0111; fn[7]  = 6'b101010; ex[7]  = 6'b1100_00;
    op[8]  = 4'b0111; fn[8]  = 6'b001000; ex[8]  = 6'b0000_10;
    op[9]  = 4'b0111; fn[9]  = 6'b111111; ex[9]  = 6'b1111_01;
    op[10] = 4'b0000; fn[10] = 6'b101010; ex[10] = 6'b0000_00;
    op[11] = 4'b0100; fn[11] = 6'b111111; ex[11] = 6'b0000_00;
    op[12] = 4'b0101; fn[12] = 6'b011000; ex[12] = 6'b0000_00;
    op[13] = 4'b0001; fn[13] = 6'b100010; ex[13] = 6'b0010_00;
    op[14] = 4'b0010; fn[14] = 6'b000000; ex[14] = 6'b0011_00;
    op[15] = 4'b0011; fn[15] = 6'b001000; ex[15] = 6'b0101_00;
    op[16] = 4'b1000; fn[16] = 6'b100000; ex[16] = 6'b0001_00;
    op[17] = 4'b1001; fn[17] = 6'b011010; ex[17] = 6'b0001_00;
    op[18] = 4'b0110; fn[18] = 6'b100000; ex[18] = 6'b1111_01;
    op[19] = 4'b1111; fn[19] = 6'b100000; ex[19] = 6'b1111_01;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid    = 1'b1;
      bus.ALUOp       = op[i];
      bus.ALUFunction = fn[i];
      step();
      n_total++;
      if ({bus.out_valid, bus.ALUOperation, bus.Jr, bus.Illegal} !== {1'b1, ex[i]})
        $display("FAIL decode[%0d] op=%b fn=%b: got %b expected %b", i, op[i], fn[i],
                 {bus.out_valid, bus.ALUOperation, bus.Jr, bus.Illegal}, {1'b1, ex[i]});
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_div;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.ALUOp       = 4'b0111;
    bus.ALUFunction = 6'b011010;
    step();
    bus.in_valid = 1'b0;
`ifdef ALU_CONTROL_DIV_EN
    for (int c = 1; c <= 15; c++) begin
      n_total++;
      if ({bus.Busy, bus.out_valid} !== 2'b10)
        $display("FAIL div_wait[c%0d]: got busy/out_valid %b expected 10", c,
                 {bus.Busy, bus.out_valid});
      else n_pass++;
      step();
    end
    n_total++;
    if ({bus.out_valid, bus.ALUOperation, bus.Illegal} !== 6'b1_1010_0)
      $display("FAIL div_done: got %b expected 110100",
               {bus.out_valid, bus.ALUOperation, bus.Illegal});
    else n_pass++;
`else
    n_total++;
    if ({bus.out_valid, bus.Busy, bus.ALUOperation, bus.Illegal} !== 7'b10_1111_1)
      $display("FAIL div_illegal: got %b expected 1011111",
               {bus.out_valid, bus.Busy, bus.ALUOperation, bus.Illegal});
    else n_pass++;
`endif
    step();
  endtask

  task automatic test_reset_mid_op;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.ALUOp       = 4'b0111;
    bus.ALUFunction = 6'b011001;
    step();
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus.out_valid, bus.Busy, bus.ALUOperation, bus.Jr, bus.Illegal, bus.in_ready} !== 9'b000000001)
      $display("FAIL reset_wait_now: got %b expected 000000001",
               {bus.out_valid, bus.Busy, bus.ALUOperation, bus.Jr, bus.Illegal, bus.in_ready});
    else n_pass++;
    step();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      n_total++;
      if ({bus.out_valid, bus.Busy} !== 2'b00)
        $display("FAIL reset_wait_after[%0d]: got out_valid/busy %b expected 00", c,
                 {bus.out_valid, bus.Busy});
      else n_pass++;
    end
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.ALUOp       = 4'b0111;
    bus.ALUFunction = 6'b100000;
    step();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_hold_now: got out_valid %b expected 0", bus.out_valid);
    else n_pass++;
    step();
    reset = 1'b1;
    step();
    step();
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_hold_after: got out_valid %b expected 0", bus.out_valid);
    else n_pass++;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_back_to_back();
    test_mult();
    test_hold_stall();
    test_decode();
    test_div();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
